// File: rtl/secure_comm_pkg.sv
// Shared types and constants for the secure-comm payload path.
package secure_comm_pkg;

  localparam int WORD_W      = 32;
  localparam int N_WORDS     = 8;
  localparam int KEY_W       = 128;
  localparam int FRAME_CNT_W = 16;
  localparam int PAYLOAD_W   = WORD_W * N_WORDS;
  localparam int IDX_W       = $clog2(N_WORDS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SEND  = 3'd2,
    TAG   = 3'd3,
    CLEAR = 3'd4
  } state_t;

  // Per-word tweak mixed into the keystream: frame number in the top bits,
  // word index in the bottom bits, zeros between.
  function automatic logic [WORD_W-1:0] ks_tweak(
    input logic [FRAME_CNT_W-1:0] fc,
    input logic [IDX_W-1:0]       idx
  );
    return {fc, {(WORD_W-FRAME_CNT_W-IDX_W){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/keystream_gen.sv
// Key register with per-word rotation and keystream word generation.
// ks is the keystream for the current word; ks_next is the keystream the
// following word will use once the key has rotated, so the top can register
// the next ciphertext word in the same cycle as the current word's accept.
module keystream_gen
  import secure_comm_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [KEY_W-1:0]       key_in,
  input  logic                   advance,
  input  logic                   clear,
  input  logic [IDX_W-1:0]       idx,
  input  logic [FRAME_CNT_W-1:0] frame_count,
  output logic [WORD_W-1:0]      ks,
  output logic [WORD_W-1:0]      ks_next
);

  logic [KEY_W-1:0] key_reg;
  logic [IDX_W-1:0] idx_next;

  // Key storage: load on frame accept, rotate left one word per accepted
  // word, zeroize at end of frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_reg <= '0;
    end else if (clear) begin
      key_reg <= '0;
    end else if (load) begin
      key_reg <= key_in;
    end else if (advance) begin
      key_reg <= {key_reg[KEY_W-WORD_W-1:0], key_reg[KEY_W-1 -: WORD_W]};
    end
  end

  assign idx_next = idx + IDX_W'(1);

  // After a rotate-left by one word, the new low word is the current top word.
  assign ks      = key_reg[WORD_W-1:0]       ^ ks_tweak(frame_count, idx);
  assign ks_next = key_reg[KEY_W-1 -: WORD_W] ^ ks_tweak(frame_count, idx_next);

endmodule

// File: rtl/secure_payload_serializer.sv
// Encrypts a 256-bit payload with a key-derived keystream and streams it out
// as N_WORDS ciphertext words followed by one XOR tag word. Payload, key and
// tag storage are zeroized after every frame.
//
// Handshakes (valid/ready): a transfer happens on a rising edge where both
// valid and ready are high. in_ready is high only in IDLE and does not depend
// on in_valid. tx_valid, once high, stays high with tx_data/tx_is_tag/tx_last
// unchanged until the cycle in which tx_ready is also high; tx_valid does not
// depend on tx_ready.
module secure_payload_serializer
  import secure_comm_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PAYLOAD_W-1:0]   in_payload,
  input  logic [KEY_W-1:0]       in_key,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [WORD_W-1:0]      tx_data,
  output logic                   tx_is_tag,
  output logic                   tx_last,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output state_t                 state_dbg
);

  state_t                 state_q, state_d;
  logic [PAYLOAD_W-1:0]   payload_reg;
  logic [WORD_W-1:0]      tag_reg;
  logic [WORD_W-1:0]      tx_data_reg;
  logic [IDX_W-1:0]       idx_q;
  logic [IDX_W-1:0]       idx_next;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic                   in_hs;
  logic                   tx_hs;
  logic                   last_word;
  logic [WORD_W-1:0]      ks;
  logic [WORD_W-1:0]      ks_next;
  logic [WORD_W-1:0]      ct_cur;
  logic [WORD_W-1:0]      ct_next;

  assign in_hs     = in_valid & in_ready;
  assign tx_hs     = tx_valid & tx_ready;
  assign idx_next  = idx_q + IDX_W'(1);
  assign last_word = (idx_q == IDX_W'(N_WORDS - 1));

  keystream_gen u_ks (
    .clk         (clk),
    .reset       (reset),
    .load        (in_hs),
    .key_in      (in_key),
    .advance     ((state_q == SEND) && tx_hs),
    .clear       (state_q == CLEAR),
    .idx         (idx_q),
    .frame_count (frame_cnt_q),
    .ks          (ks),
    .ks_next     (ks_next)
  );

  // Ciphertext only ever reaches tx_data_reg; cleartext words stay internal.
  assign ct_cur  = payload_reg[WORD_W*idx_q    +: WORD_W] ^ ks;
  assign ct_next = payload_reg[WORD_W*idx_next +: WORD_W] ^ ks_next;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake/flag outputs, all decoded from the current state.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    tx_valid  = 1'b0;
    tx_is_tag = 1'b0;
    tx_last   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = LOAD;
      end
      LOAD: begin
        state_d = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        if (tx_ready && last_word) state_d = TAG;
      end
      TAG: begin
        tx_valid  = 1'b1;
        tx_is_tag = 1'b1;
        tx_last   = 1'b1;
        if (tx_ready) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Payload capture, word index, tag accumulation and the output word
  // register; everything is zeroized in CLEAR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      payload_reg <= '0;
      tag_reg     <= '0;
      tx_data_reg <= '0;
      idx_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_hs) begin
            payload_reg <= in_payload;
            tag_reg     <= '0;
            idx_q       <= '0;
          end
        end
        LOAD: begin
          tx_data_reg <= ct_cur;
        end
        SEND: begin
          if (tx_hs) begin
            tag_reg <= tag_reg ^ tx_data_reg;
            idx_q   <= idx_next;
            if (last_word) begin
              tx_data_reg <= tag_reg ^ tx_data_reg;
            end else begin
              tx_data_reg <= ct_next;
            end
          end
        end
        TAG: begin
          if (tx_hs) tx_data_reg <= '0;
        end
        CLEAR: begin
          payload_reg <= '0;
          tag_reg     <= '0;
          tx_data_reg <= '0;
          idx_q       <= '0;
        end
        default: begin
          tx_data_reg <= '0;
        end
      endcase
    end
  end

  // Completed-frame counter, stepped only on the tag handshake; wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else if ((state_q == TAG) && tx_hs) begin
      frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
    end
  end

  assign tx_data     = tx_data_reg;
  assign busy        = (state_q != IDLE);
  assign frame_count = frame_cnt_q;
  assign state_dbg   = state_q;

endmodule
